// File: rtl/dsp_inverse.sv
// dsp_inverse: exact FIR inverse of the second-order difference-equation block.
// Recovers x[n] = y[n] - ((A1*y[n-1] + A2*y[n-2]) >>> SHIFT), mod 256.
// The datapath is a two-stage valid/ready pipeline. Stage 1 computes the
// sample and stage 2 drives the output register.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   clear     in   synchronous flush of history, pipeline and count (active-high)
//   y         in   [7:0] forward-filter output sample (two's complement)
//   in_valid  in   y is valid this cycle
//   in_ready  out  block accepts y this cycle (combinational)
//   x         out  [7:0] recovered excitation (two's complement, registered)
//   out_valid out  x is valid (registered)
//   out_ready in   downstream accepts x
//   count     out  [7:0] samples emitted since reset/clear, wraps at 256
module dsp_inverse #(
  parameter logic signed [7:0] A1    = 8'sd1,
  parameter logic signed [7:0] A2    = 8'sd0,
  parameter int unsigned       SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [7:0] y,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] x,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] count
);

  logic [7:0] y1_q, y1_d;
  logic [7:0] y2_q, y2_d;
  logic       s1_valid_q, s1_valid_d;
  logic [7:0] s1_x_q, s1_x_d;
  logic       s2_valid_q, s2_valid_d;
  logic [7:0] s2_x_q, s2_x_d;
  logic [7:0] count_q, count_d;

  logic               in_xfer_s;
  logic               out_xfer_s;
  logic               s2_load_s;
  logic signed [15:0] p1_s;
  logic signed [15:0] p2_s;
  logic signed [16:0] fb_sum_s;
  logic signed [16:0] fb_sh_s;
  logic [7:0]         x_new_s;

  // Handshake decode: stage 2 can load when empty or when its sample is leaving.
  always_comb begin
    s2_load_s  = !s2_valid_q || out_ready;
    out_xfer_s = s2_valid_q && out_ready;
    in_ready   = !clear && (!s1_valid_q || s2_load_s);
    in_xfer_s  = in_valid && in_ready;
  end

  // Feedback term: 8x8 signed products, 17-bit sum, floor shift, keep low byte.
  always_comb begin
    p1_s     = $signed({{8{A1[7]}}, A1}) * $signed({{8{y1_q[7]}}, y1_q});
    p2_s     = $signed({{8{A2[7]}}, A2}) * $signed({{8{y2_q[7]}}, y2_q});
    fb_sum_s = $signed({p1_s[15], p1_s}) + $signed({p2_s[15], p2_s});
    fb_sh_s  = fb_sum_s >>> SHIFT;
    x_new_s  = y - fb_sh_s[7:0];
  end

  // Next-state logic for history, both stages and the output counter.
  always_comb begin
    y1_d       = y1_q;
    y2_d       = y2_q;
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s2_valid_d = s2_valid_q;
    s2_x_d     = s2_x_q;
    count_d    = count_q;
    if (clear) begin
      // Flush wins over every transfer in the same cycle.
      y1_d       = 8'd0;
      y2_d       = 8'd0;
      s1_valid_d = 1'b0;
      s1_x_d     = 8'd0;
      s2_valid_d = 1'b0;
      s2_x_d     = 8'd0;
      count_d    = 8'd0;
    end else begin
      if (s2_load_s) begin
        s2_valid_d = s1_valid_q;
        s2_x_d     = s1_x_q;
      end else begin
        s2_valid_d = s2_valid_q;
        s2_x_d     = s2_x_q;
      end
      if (in_xfer_s) begin
        s1_valid_d = 1'b1;
        s1_x_d     = x_new_s;
        y2_d       = y1_q;
        y1_d       = y;
      end else if (s2_load_s) begin
        // Stage 1 contents (if any) moved into stage 2.
        s1_valid_d = 1'b0;
      end else begin
        s1_valid_d = s1_valid_q;
      end
      if (out_xfer_s) begin
        count_d = count_q + 8'd1;
      end else begin
        count_d = count_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y1_q       <= 8'd0;
      y2_q       <= 8'd0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= 8'd0;
      s2_valid_q <= 1'b0;
      s2_x_q     <= 8'd0;
      count_q    <= 8'd0;
    end else begin
      y1_q       <= y1_d;
      y2_q       <= y2_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s2_valid_q <= s2_valid_d;
      s2_x_q     <= s2_x_d;
      count_q    <= count_d;
    end
  end

  // Output drivers come straight from registers.
  always_comb begin
    x         = s2_x_q;
    out_valid = s2_valid_q;
    count     = count_q;
  end

endmodule

// File: doc/dsp_inverse.md
Name: dsp_inverse

Overview:
- Inverse system for the second-order constant-coefficient difference equation block. Recovers the excitation x[n] from that block's output y[n].
- Forward equation: y[n] = x[n] + ((A1*y[n-1] + A2*y[n-2]) >>> SHIFT), mod 256.
- Inverse is FIR and exact: x[n] = y[n] - ((A1*y[n-1] + A2*y[n-2]) >>> SHIFT), mod 256.
- Sits downstream of the forward filter for loopback self-check and system identification. Uses a 2-stage valid/ready pipeline.

Parameters:
- A1, 1, signed 8-bit feedback coefficient on y[n-1]; must equal the forward block's value.
- A2, 0, signed 8-bit feedback coefficient on y[n-2].
- SHIFT, 0, arithmetic right shift applied to the feedback sum, range 0..7.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous history and pipeline flush, active-high.
- y  input  8  forward-filter output sample, two's complement.
- in_valid  input  1  y is valid this cycle.
- in_ready  output  1  block accepts y this cycle.
- x  output  8  recovered excitation, two's complement.
- out_valid  output  1  x is valid.
- out_ready  input  1  downstream accepts x.
- count  output  8  number of samples emitted since reset/clear; wraps at 256.

Behaviour:
- Reset (reset=0, asynchronous): clears y1, y2, both stage registers and their valid bits, and count. Outputs during and after reset: x=0, out_valid=0, count=0, in_ready=1.
- Reset mid-operation: any in-flight samples are discarded with no partial output. The first sample after release is treated as n=0 with zero history.
- Input transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- Stage 1, on input transfer:
  - Latches s1_y = y.
  - Computes fb = (A1*y1 + A2*y2) as a 17-bit signed value from 8x8 signed products, then fb >>> SHIFT (floor), truncated to the low 8 bits.
  - Registers s1_x = (y - fb) mod 256.
  - Shifts history: y2 <= y1, y1 <= y.
  - History advances only on input transfer, never on stall cycles.
- Stage 2: holds x and out_valid. It loads from stage 1 when stage 2 is empty or an output transfer happens in the same cycle.
- in_ready = !s1_valid || (!s2_valid || out_ready). This is combinational and gives full throughput of one sample per clock.
- Latency: 2 clocks from input transfer to out_valid when out_ready stays high.
- Backpressure: with out_ready=0, the pipeline fills after at most 2 accepted samples and then in_ready=0. x must hold stable while out_valid && !out_ready. No sample is dropped or duplicated.
- Simultaneous input and output transfer when full: stage 2 takes stage 1 and stage 1 takes the new input in the same clock.
- clear=1 at a clock edge:
  - Zeros y1, y2 and count, drops both valid bits, and ignores any input presented in that cycle.
  - in_ready is forced to 0 while clear=1.
  - clear takes priority over all transfers.
- Arithmetic:
  - Every add and subtract wraps mod 256 with no saturation, matching the forward block's 8-bit wrap, so the inverse is exact even when y wraps.
  - Shift rounding is floor (>>> on signed), identical to the forward block.
- count increments on each output transfer and wraps 255 -> 0.
- Internal states per stage: EMPTY and FULL, encoded as the valid bit. There is no other FSM.

Test Plan:
- Default params, out_ready=1, y = 1,3,6,10,15,21,28,36,45,45 on consecutive clocks -> x = 1,2,3,4,5,6,7,8,9,0; each x appears 2 clocks after its y; count ends at 10.
- Wrap-around, default params: y = 250,4 (4 is 260 mod 256) -> x = 250 (-6 signed), then 10.
- A1=64, A2=-32, SHIFT=6, y = 100,50,20:
  - n=0: fb=0, x=100.
  - n=1: fb=(6400)>>>6=100, x=50-100=-50 (0xCE).
  - n=2: fb=(3200-3200)>>>6=0, x=20.
- Backpressure, default params, out_ready=0 for 5 clocks while in_valid=1 with y=1,3,6:
  - in_ready drops after 2 accepts; x holds 1 with out_valid=1 during the stall.
  - After out_ready=1: outputs 1,2,3 in order with no loss; history is correct.
- clear asserted after y=1,3 are accepted, then y=5 -> x=5 (zero history), count=1 after that output; no stale outputs appear.
- reset pulsed low mid-stream with 2 samples in flight -> out_valid=0 and count=0 immediately (asynchronous). After release, y=7 yields x=7.
